ahb_lite_sram_slave: RTL and testbench

//  AHB-Lite slave terminating the bus driven by our verification master: word-organised SRAM

---
 rtl/ahb_lite_sram_slave_pkg.sv | 65 ++++++
 rtl/ahb_sram_bank.sv | 50 +++++
 rtl/ahb_lite_sram_slave.sv | 177 +++++++++++++++++
 tb/tb_ahb_lite_sram_slave.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_lite_sram_slave_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : AHBpkg (package)
//  Purpose  : Shared AHB-Lite encodings for the SRAM slave. It holds the
//             transfer, size, burst and response enums, the slave state
//             encoding, the HRESP codes, and a byte-lane decode helper.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package AHBpkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'b000,
    HSIZE_HALF = 3'b001,
    HSIZE_WORD = 3'b010
  } hsize_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'b000,
    HBURST_INCR   = 3'b001,
    HBURST_WRAP4  = 3'b010,
    HBURST_INCR4  = 3'b011,
    HBURST_WRAP8  = 3'b100,
    HBURST_INCR8  = 3'b101,
    HBURST_WRAP16 = 3'b110,
    HBURST_INCR16 = 3'b111
  } hburst_e;

  typedef enum logic [1:0] {
    HRESP_E_OKAY  = 2'b00,
    HRESP_E_ERROR = 2'b01
  } hresp_e;

  typedef enum logic [1:0] {
    ST_OK   = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } slave_state_e;

  localparam logic [1:0] c_HRESP_OKAY  = 2'b00;
  localparam logic [1:0] c_HRESP_ERROR = 2'b01;

  // Little-endian byte-lane enables for a transfer of the given size at the
  // given low address bits. Sizes above a word are never legal, so they fall
  // back to the full word here.
  function automatic logic [3:0] lane_be(input logic [2:0] size, input logic [1:0] a);
    logic [3:0] be;
    case (size)
      3'b000:  be = 4'b0001 << a;
      3'b001:  be = a[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_sram_bank.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_sram_bank
//  Purpose  : MEM_DEPTH x 32-bit word array with per-byte write enables and
//             a registered (synchronous) read port. The array itself is not
//             reset; only the read-data register clears.
//  Ports    : clk      in   clock
//             rst      in   synchronous active-high reset (read register only)
//             i_we     in   4-bit byte-lane write enable
//             i_waddr  in   write word index
//             i_wdata  in   write data
//             i_re     in   read enable
//             i_raddr  in   read word index
//             o_rdata  out  registered read data
//  Revision : 1.0  initial release
// ============================================================================
module ahb_sram_bank #(
  parameter int MEM_DEPTH = 1024,
  parameter int AW        = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [MEM_DEPTH];
  logic [31:0] r_rdata;

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (i_we[b]) r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
    end
  end

  // A read on the same edge as a write returns the old contents; the top
  // level patches in the freshly written lanes.
  always_ff @(posedge clk) begin
    if (rst)       r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/ahb_lite_sram_slave.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_lite_sram_slave
//  Purpose  : AHB-Lite slave in front of a word-organised SRAM. It supports
//             byte, half and word transfers, registered reads, a write-to-read
//             bypass, and a two-cycle ERROR response for illegal accesses.
//             Build option AHB_WAIT_STATES_EN inserts WAIT_CYCLES wait states
//             into every legal NONSEQ/SEQ data phase.
//  Ports    : HCLK    in   bus clock
//             HRESET  in   synchronous active-high reset
//             HADDR   in   byte address (address phase)
//             HTRANS  in   transfer type
//             HWRITE  in   1 = write
//             HSIZE   in   transfer size (byte/half/word)
//             HBURST  in   burst type (not checked)
//             HWDATA  in   write data (data phase)
//             HREADY  out  transfer done / slave ready
//             HRESP   out  00 OKAY, 01 ERROR
//             HRDATA  out  read data
//  Revision : 1.0  initial release
// ============================================================================
module ahb_lite_sram_slave
  import AHBpkg::*;
#(
  parameter int MEM_DEPTH   = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [31:0] HWDATA,
  output logic        HREADY,
  output logic [1:0]  HRESP,
  output logic [31:0] HRDATA
);

  localparam int c_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  slave_state_e    r_state;
  logic            r_hready;
  logic [1:0]      r_hresp;
  logic            r_wr_pend;
  logic [c_AW-1:0] r_wr_idx;
  logic [3:0]      r_wr_be;
  logic [3:0]      r_byp_be;
  logic [31:0]     r_byp_data;

  logic            w_accept;
  logic            w_legal;
  logic [c_AW-1:0] w_idx;
  logic [3:0]      w_be;
  logic            w_commit;
  logic            w_rd_go;
  logic [3:0]      w_bank_we;
  logic [31:0]     w_bank_rdata;
  logic [31:0]     w_byp_mask;

  // A new address phase is taken only while our own HREADY is high.
  assign w_accept = r_hready & HTRANS[1];
  assign w_legal  = ({2'b00, HADDR[31:2]} < 32'(MEM_DEPTH))
                  && (HSIZE <= 3'b010)
                  && !((HSIZE == 3'b001) && HADDR[0])
                  && !((HSIZE == 3'b010) && (HADDR[1:0] != 2'b00));
  assign w_idx    = HADDR[c_AW+1:2];
  assign w_be     = lane_be(HSIZE, HADDR[1:0]);
  // A pending write commits on the edge that closes its data phase, which is
  // the first edge where HREADY is high again.
  assign w_commit = r_wr_pend & r_hready;
  assign w_rd_go  = w_accept & w_legal & ~HWRITE;
  assign w_bank_we = (w_commit && !HRESET) ? r_wr_be : 4'b0000;

  ahb_sram_bank #(
    .MEM_DEPTH (MEM_DEPTH),
    .AW        (c_AW)
  ) u_bank (
    .clk     (HCLK),
    .rst     (HRESET),
    .i_we    (w_bank_we),
    .i_waddr (r_wr_idx),
    .i_wdata (HWDATA),
    .i_re    (w_rd_go),
    .i_raddr (w_idx),
    .o_rdata (w_bank_rdata)
  );

  // Remember which lanes of the word being read were written on the same
  // edge, so the returned data reflects the newer value.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_byp_be   <= 4'b0000;
      r_byp_data <= '0;
    end else if (w_rd_go) begin
      r_byp_be   <= (w_commit && (r_wr_idx == w_idx)) ? r_wr_be : 4'b0000;
      r_byp_data <= HWDATA;
    end
  end

  always_comb begin
    w_byp_mask = '0;
    for (int b = 0; b < 4; b++) w_byp_mask[8*b +: 8] = {8{r_byp_be[b]}};
  end

  assign HRDATA = (w_bank_rdata & ~w_byp_mask) | (r_byp_data & w_byp_mask);
  assign HREADY = r_hready;
  assign HRESP  = r_hresp;

`ifdef AHB_WAIT_STATES_EN
  localparam int c_WCW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;
  logic [c_WCW-1:0] r_wait_cnt;
  logic             w_unused;
  assign w_unused = &{1'b0, HBURST, HTRANS[0]};
`else
  logic w_unused;
  assign w_unused = &{1'b0, HBURST, HTRANS[0], WAIT_CYCLES[0]};
`endif

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state   <= ST_OK;
      r_hready  <= 1'b1;
      r_hresp   <= c_HRESP_OKAY;
      r_wr_pend <= 1'b0;
      r_wr_idx  <= '0;
      r_wr_be   <= 4'b0000;
`ifdef AHB_WAIT_STATES_EN
      r_wait_cnt <= '0;
`endif
    end else begin
      case (r_state)
        ST_ERR1: begin
          r_state  <= ST_ERR2;
          r_hready <= 1'b1;
          r_hresp  <= c_HRESP_ERROR;
        end
`ifdef AHB_WAIT_STATES_EN
        ST_WAIT: begin
          if (r_wait_cnt == '0) begin
            r_state  <= ST_OK;
            r_hready <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt - 1'b1;
          end
        end
`endif
        default: begin
          // ST_OK and ST_ERR2 both have HREADY high and sample normally.
          r_state   <= ST_OK;
          r_hready  <= 1'b1;
          r_hresp   <= c_HRESP_OKAY;
          r_wr_pend <= 1'b0;
          if (w_accept) begin
            if (!w_legal) begin
              r_state  <= ST_ERR1;
              r_hready <= 1'b0;
              r_hresp  <= c_HRESP_ERROR;
            end else begin
              r_wr_pend <= HWRITE;
              r_wr_idx  <= w_idx;
              r_wr_be   <= w_be;
`ifdef AHB_WAIT_STATES_EN
              r_state    <= ST_WAIT;
              r_hready   <= 1'b0;
              r_wait_cnt <= c_WCW'(WAIT_CYCLES - 1);
`endif
            end
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ahb_lite_sram_slave.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ahb_lite_sram_slave
//  Purpose  : Self-checking bench for ahb_lite_sram_slave. A table of bus
//             transfers with expected responses is issued through a
//             pipelined AHB-Lite master; expectations ride a scoreboard queue
//             from address phase to data-phase completion. A hand-written
//             sequence covers reset during a pending write. Honours
//             AHB_WAIT_STATES_EN for the expected wait-state count.
//  Ports    : none
//  Revision : 1.0  initial release
// ============================================================================
module tb_ahb_lite_sram_slave;

  localparam int MEM_DEPTH   = 1024;
  localparam int WAIT_CYCLES = 2;
`ifdef AHB_WAIT_STATES_EN
  localparam int c_WAITS = WAIT_CYCLES;
`else
  localparam int c_WAITS = 0;
`endif

  localparam logic [1:0] c_IDLE = 2'b00;
  localparam logic [1:0] c_BUSY = 2'b01;
  localparam logic [1:0] c_NSQ  = 2'b10;
  localparam logic [1:0] c_SEQ  = 2'b11;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic [31:0] HADDR = '0;
  logic [1:0]  HTRANS = 2'b00;
  logic        HWRITE = 1'b0;
  logic [2:0]  HSIZE = 3'b010;
  logic [2:0]  HBURST = 3'b000;
  logic [31:0] HWDATA = '0;
  logic        HREADY;
  logic [1:0]  HRESP;
  logic [31:0] HRDATA;

  ahb_lite_sram_slave #(
    .MEM_DEPTH   (MEM_DEPTH),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) dut (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .HADDR  (HADDR),
    .HTRANS (HTRANS),
    .HWRITE (HWRITE),
    .HSIZE  (HSIZE),
    .HBURST (HBURST),
    .HWDATA (HWDATA),
    .HREADY (HREADY),
    .HRESP  (HRESP),
    .HRDATA (HRDATA)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic        chk_rd;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic        err;
    logic        chk_rd;
    logic [31:0] rdata;
    int          waits;
    logic [31:0] wdata;
    int          id;
  } exp_t;

  vec_t vecs[$];
  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;
  int   vec_base = 0;

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec%0d: got %h expected %h", nm, id, act, exp);
    end
  endtask

  task automatic add(input logic [1:0] tr, input logic w, input logic [2:0] sz,
                     input logic [31:0] a, input logic [31:0] d,
                     input logic err, input logic rd, input logic [31:0] exp_rd);
    vecs.push_back('{tr, w, sz, a, d, err, rd, exp_rd});
  endtask

  // Pipelined master: drives at posedge+1, samples at negedge, holds the
  // address phase while HREADY is low.
  task automatic run_vecs();
    int          ia = 0;
    int          lows = 0;
    logic [1:0]  lowresp = 2'b00;
    int          guard = 0;
    exp_t        e;
    while ((ia < vecs.size() || sbq.size() != 0) && guard < 1000) begin
      if (ia < vecs.size()) begin
        HTRANS = vecs[ia].trans;
        HWRITE = vecs[ia].write;
        HSIZE  = vecs[ia].size;
        HADDR  = vecs[ia].addr;
      end else begin
        HTRANS = c_IDLE;
        HWRITE = 1'b0;
        HSIZE  = 3'b010;
        HADDR  = '0;
      end
      HWDATA = (sbq.size() != 0) ? sbq[0].wdata : 32'h0;
      @(negedge HCLK);
      if (sbq.size() != 0) begin
        if (HREADY !== 1'b1) begin
          lows++;
          if (lows == 1) lowresp = HRESP;
        end else begin
          e = sbq.pop_front();
          chk("hresp", e.id, {30'b0, HRESP}, e.err ? 32'h1 : 32'h0);
          chk("wait_cycles", e.id, 32'(lows), 32'(e.waits));
          if (e.err) chk("err_first_resp", e.id, {30'b0, lowresp}, 32'h1);
          if (e.chk_rd) chk("hrdata", e.id, HRDATA, e.rdata);
          lows    = 0;
          lowresp = 2'b00;
        end
      end
      if (HREADY === 1'b1 && ia < vecs.size()) begin
        e.err    = vecs[ia].exp_err;
        e.chk_rd = vecs[ia].chk_rd;
        e.rdata  = vecs[ia].exp_rdata;
        e.waits  = vecs[ia].exp_err ? 1 : (vecs[ia].trans[1] ? c_WAITS : 0);
        e.wdata  = vecs[ia].wdata;
        e.id     = vec_base + ia;
        sbq.push_back(e);
        ia++;
      end
      @(posedge HCLK);
      #1;
      guard++;
    end
    if (guard >= 1000) begin
      checks++;
      failures++;
      $display("FAIL timeout: pending=%0d issued=%0d of %0d", sbq.size(), ia, vecs.size());
      sbq.delete();
    end
    vec_base += vecs.size();
    vecs.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    chk("reset_hready", -1, {31'b0, HREADY}, 32'h1);
    chk("reset_hresp", -1, {30'b0, HRESP}, 32'h0);
    chk("reset_hrdata", -1, HRDATA, 32'h0);
    @(posedge HCLK);
    #1;
    HRESET = 1'b0;

    //   trans   w     size    addr          wdata         err   rd    exp rdata
    add(c_NSQ,  1'b1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
    add(c_IDLE, 1'b0, 3'b010, 32'h0000_0000, 32'h0,         1'b0, 1'b0, 32'h0);
    add(c_NSQ,  1'b0, 3'b010, 32'h0000_0010, 32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF);
    add(c_NSQ,  1'b1, 3'b010, 32'h0000_0010, 32'h1122_3344, 1'b0, 1'b0, 32'h0);
    add(c_IDLE, 1'b0, 3'b010, 32'h0000_0000, 32'h0,         1'b0, 1'b0, 32'h0);
    add(c_NSQ,  1'b1, 3'b000, 32'h0000_0013, 32'hA500_0000, 1'b0, 1'b0, 32'h0);
    add(c_BUSY, 1'b0, 3'b010, 32'h0000_0000, 32'h0,         1'b0, 1'b0, 32'h0);
    add(c_NSQ,  1'b0, 3'b010, 32'h0000_0010, 32'h0,         1'b0, 1'b1, 32'hA522_3344);
    add(c_NSQ,  1'b0, 3'b010, 32'h0000_1000, 32'h0,         1'b1, 1'b0, 32'h0);
    add(c_NSQ,  1'b0, 3'b010, 32'h0000_0010, 32'h0,         1'b0, 1'b1, 32'hA522_3344);
    add(c_NSQ,  1'b1, 3'b010, 32'h0000_0020, 32'hCAFE_BABE, 1'b0, 1'b0, 32'h0);
    add(c_IDLE, 1'b0, 3'b010, 32'h0000_0000, 32'h0,         1'b0, 1'b0, 32'h0);
    add(c_NSQ,  1'b1, 3'b001, 32'h0000_0021, 32'h1234_5678, 1'b1, 1'b0, 32'h0);
    add(c_IDLE, 1'b0, 3'b010, 32'h0000_0000, 32'h0,         1'b0, 1'b0, 32'h0);
    add(c_NSQ,  1'b0, 3'b010, 32'h0000_0020, 32'h0,         1'b0, 1'b1, 32'hCAFE_BABE);
    add(c_NSQ,  1'b1, 3'b010, 32'h0000_0008, 32'h0BAD_F00D, 1'b0, 1'b0, 32'h0);
    add(c_NSQ,  1'b0, 3'b010, 32'h0000_0008, 32'h0,         1'b0, 1'b1, 32'h0BAD_F00D);
    add(c_NSQ,  1'b1, 3'b010, 32'h0000_0030, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0);
    add(c_SEQ,  1'b1, 3'b000, 32'h0000_0030, 32'h0000_00AB, 1'b0, 1'b0, 32'h0);
    add(c_SEQ,  1'b0, 3'b010, 32'h0000_0030, 32'h0,         1'b0, 1'b1, 32'hFFFF_FFAB);
    add(c_NSQ,  1'b1, 3'b001, 32'h0000_0022, 32'hBEEF_0000, 1'b0, 1'b0, 32'h0);
    add(c_NSQ,  1'b0, 3'b000, 32'h0000_0022, 32'h0,         1'b0, 1'b1, 32'hBEEF_BABE);
    add(c_NSQ,  1'b0, 3'b011, 32'h0000_0000, 32'h0,         1'b1, 1'b0, 32'h0);
    add(c_NSQ,  1'b0, 3'b010, 32'h0000_0002, 32'h0,         1'b1, 1'b0, 32'h0);
    add(c_NSQ,  1'b1, 3'b010, 32'h0000_0FFC, 32'h0000_0000, 1'b0, 1'b0, 32'h0);
    add(c_NSQ,  1'b1, 3'b000, 32'h0000_0FFF, 32'h7700_0000, 1'b0, 1'b0, 32'h0);
    add(c_IDLE, 1'b0, 3'b010, 32'h0000_0000, 32'h0,         1'b0, 1'b0, 32'h0);
    add(c_NSQ,  1'b0, 3'b010, 32'h0000_0FFC, 32'h0,         1'b0, 1'b1, 32'h7700_0000);
    add(c_NSQ,  1'b1, 3'b010, 32'hFFFF_FFFC, 32'h5555_5555, 1'b1, 1'b0, 32'h0);
    add(c_NSQ,  1'b0, 3'b010, 32'h0000_0008, 32'h0,         1'b0, 1'b1, 32'h0BAD_F00D);
    add(c_NSQ,  1'b1, 3'b010, 32'h0000_0040, 32'h1111_1111, 1'b0, 1'b0, 32'h0);
    run_vecs();

    // Reset while a write to 0x40 is still in its data phase.
    HTRANS = c_NSQ;
    HWRITE = 1'b1;
    HSIZE  = 3'b010;
    HADDR  = 32'h0000_0040;
    HWDATA = 32'h0;
    @(posedge HCLK);
    #1;
    HTRANS = c_IDLE;
    HWRITE = 1'b0;
    HWDATA = 32'h2222_2222;
    HRESET = 1'b1;
    @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    HWDATA = 32'h0;
    @(negedge HCLK);
    chk("rst_mid_hready", -2, {31'b0, HREADY}, 32'h1);
    chk("rst_mid_hresp", -2, {30'b0, HRESP}, 32'h0);
    chk("rst_mid_hrdata", -2, HRDATA, 32'h0);
    @(posedge HCLK);
    #1;

    add(c_NSQ,  1'b0, 3'b010, 32'h0000_0040, 32'h0,         1'b0, 1'b1, 32'h1111_1111);
    add(c_IDLE, 1'b0, 3'b010, 32'h0000_0000, 32'h0,         1'b0, 1'b0, 32'h0);
    add(c_NSQ,  1'b0, 3'b010, 32'h0000_0010, 32'h0,         1'b0, 1'b1, 32'hA522_3344);
    run_vecs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
